// File: rtl/speck_key_schedule_pkg.sv
// Shared definitions for the SPECK key schedule: FSM state encoding and
// the SPECK64/128 cipher defaults used by the schedule and its step function.
package speck_key_schedule_pkg;

    localparam int SPECK_ALPHA  = 8;
    localparam int SPECK_BETA   = 3;
    localparam int SPECK_ROUNDS = 27;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EMIT = 3'd2,
        ST_DONE = 3'd3
    } state_e;

    localparam logic [2:0] MAX_STATE = 3'd3;

endpackage

// File: rtl/speck_key_step.sv
// One SPECK key-expansion step, purely combinational:
// nl = (k + ROR(l0, ALPHA)) ^ i,  nk = ROL(k, BETA) ^ nl.
module speck_key_step #(
    parameter int WORD_SIZE = 32,
    parameter int ALPHA     = 8,
    parameter int BETA      = 3,
    parameter int IDX_W     = 5
) (
    input  logic [WORD_SIZE-1:0] k,
    input  logic [WORD_SIZE-1:0] l0,
    input  logic [IDX_W-1:0]     idx,
    output logic [WORD_SIZE-1:0] nk,
    output logic [WORD_SIZE-1:0] nl
);

    logic [WORD_SIZE-1:0] l0_ror;
    logic [WORD_SIZE-1:0] k_rol;

    // A zero amount is special-cased so the complementary shift never spans the full width.
    generate
        if (ALPHA == 0) begin : g_ror_none
            assign l0_ror = l0;
        end else begin : g_ror
            assign l0_ror = (l0 >> ALPHA) | (l0 << (WORD_SIZE - ALPHA));
        end

        if (BETA == 0) begin : g_rol_none
            assign k_rol = k;
        end else begin : g_rol
            assign k_rol = (k << BETA) | (k >> (WORD_SIZE - BETA));
        end
    endgenerate

    assign nl = (k + l0_ror) ^ WORD_SIZE'(idx);
    assign nk = k_rol ^ nl;

endmodule

// File: rtl/speck_key_schedule.sv
// SPECK key schedule: expands the master key into ROUNDS subkeys and presents
// them one per round on a valid/ack handshake to the round-encrypt stage.
module speck_key_schedule
    import speck_key_schedule_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = SPECK_ROUNDS,
    parameter int ALPHA     = SPECK_ALPHA,
    parameter int BETA      = SPECK_BETA,
    parameter int IDX_W     = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [KEY_WORDS*WORD_SIZE-1:0] key,
    input  logic                           key_load,
    output logic [WORD_SIZE-1:0]           subkey,
    output logic                           subkey_valid,
    input  logic                           subkey_ack,
    output logic [IDX_W-1:0]               round_idx,
    output logic                           busy,
    output logic                           done,
    output logic [2:0]                     state_response
);

    localparam int L_WORDS = KEY_WORDS - 1;

    state_e                             state_q, state_d;
    logic [WORD_SIZE-1:0]               k_q, k_d;
    logic [L_WORDS-1:0][WORD_SIZE-1:0]  l_q, l_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               done_q, done_d;

    logic                 load_accept;
    logic                 last_round;
    logic                 step_en;
    logic [WORD_SIZE-1:0] nk;
    logic [WORD_SIZE-1:0] nl;

    assign load_accept = key_load && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_round  = (idx_q == IDX_W'(ROUNDS - 1));
    assign step_en     = (state_q == ST_EMIT) && subkey_ack;

    speck_key_step #(
        .WORD_SIZE (WORD_SIZE),
        .ALPHA     (ALPHA),
        .BETA      (BETA),
        .IDX_W     (IDX_W)
    ) u_step (
        .k   (k_q),
        .l0  (l_q[0]),
        .idx (idx_q),
        .nk  (nk),
        .nl  (nl)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            l_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l_q     <= l_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default at
    // the top, so no path through the branches leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (key_load) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EMIT;
            ST_EMIT: if (subkey_ack && last_round) state_d = ST_DONE;
            ST_DONE: state_d = key_load ? ST_LOAD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Key-word datapath: latch the master key on an accepted load, advance one
    // step per acked subkey except the last, which is held for DONE.
    always_comb begin
        k_d    = k_q;
        l_d    = l_q;
        idx_d  = idx_q;
        done_d = 1'b0;
        if (load_accept) begin
            k_d   = key[WORD_SIZE-1:0];
            for (int j = 0; j < L_WORDS; j++) begin
                l_d[j] = key[(j+1)*WORD_SIZE +: WORD_SIZE];
            end
            idx_d = '0;
        end else if (step_en) begin
            if (last_round) begin
                done_d = 1'b1;
            end else begin
                for (int j = 0; j < L_WORDS - 1; j++) begin
                    l_d[j] = l_q[j+1];
                end
                l_d[L_WORDS-1] = nl;
                k_d            = nk;
                idx_d          = idx_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        subkey_valid = (state_q == ST_EMIT);
        busy         = (state_q == ST_LOAD) || (state_q == ST_EMIT);
    end

    assign subkey         = k_q;
    assign round_idx      = idx_q;
    assign done           = done_q;
    assign state_response = state_q;

endmodule

// File: tb/tb_speck_key_schedule.sv
// Directed testbench for speck_key_schedule (SPECK64/128 defaults): reset,
// test-vector load, full run, backpressure, abort and load-rule scenarios.
module tb_speck_key_schedule;

    localparam int W  = 32;
    localparam int M  = 4;
    localparam int R  = 27;
    localparam int IW = 5;

    localparam logic [M*W-1:0] KEY_A = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [M*W-1:0] KEY_B = 128'hdeadbeef_cafef00d_01234567_89abcdef;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [M*W-1:0]  key = '0;
    logic            key_load = 1'b0;
    logic [W-1:0]    subkey;
    logic            subkey_valid;
    logic            subkey_ack = 1'b0;
    logic [IW-1:0]   round_idx;
    logic            busy;
    logic            done;
    logic [2:0]      state_response;

    int pass_count  = 0;
    int check_count = 0;

    logic [W-1:0] exp_keys [0:R-1];

    speck_key_schedule #(
        .WORD_SIZE (W),
        .KEY_WORDS (M),
        .ROUNDS    (R),
        .ALPHA     (8),
        .BETA      (3),
        .IDX_W     (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .key            (key),
        .key_load       (key_load),
        .subkey         (subkey),
        .subkey_valid   (subkey_valid),
        .subkey_ack     (subkey_ack),
        .round_idx      (round_idx),
        .busy           (busy),
        .done           (done),
        .state_response (state_response)
    );

    always #5 clk = ~clk;

    // Software SPECK64/128 key expansion, written with fixed bit-slice rotates.
    function automatic void build_model(input logic [M*W-1:0] mk);
        logic [31:0] k;
        logic [31:0] l0, l1, l2;
        logic [31:0] t;
        k  = mk[31:0];
        l0 = mk[63:32];
        l1 = mk[95:64];
        l2 = mk[127:96];
        for (int i = 0; i < R; i++) begin
            exp_keys[i] = k;
            t  = (k + {l0[7:0], l0[31:8]}) ^ 32'(i);
            k  = {k[28:0], k[31:29]} ^ t;
            l0 = l1;
            l1 = l2;
            l2 = t;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_load = 1'b0;
        subkey_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulses key_load for one cycle; returns at the negedge after the load edge.
    task automatic pulse_load(input logic [M*W-1:0] k);
        @(negedge clk);
        key = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        pulse_load(KEY_A);
        subkey_ack = 1'b1;
        repeat (3) @(negedge clk);
        // Assert reset while clk is low: no edge, outputs must clear at once.
        rst = 1'b1;
        subkey_ack = 1'b0;
        #1;
        check_count++;
        if ({subkey, subkey_valid, round_idx, busy, done, state_response} !== '0)
            $display("FAIL reset_async: subkey=%h valid=%b idx=%0d busy=%b done=%b state=%0d expected all zero",
                     subkey, subkey_valid, round_idx, busy, done, state_response);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_count++;
        if ({subkey_valid, busy, state_response} !== {1'b0, 1'b0, 3'd0})
            $display("FAIL reset_release_idle: valid=%b busy=%b state=%0d expected 0 0 0",
                     subkey_valid, busy, state_response);
        else pass_count++;
    endtask

    task automatic test_vector_load();
        do_reset();
        subkey_ack = 1'b0;
        pulse_load(KEY_A);
        check_count++;
        if ({state_response, busy, subkey_valid} !== {3'd1, 1'b1, 1'b0})
            $display("FAIL load_cycle: state=%0d busy=%b valid=%b expected 1 1 0",
                     state_response, busy, subkey_valid);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd0, 32'h03020100})
            $display("FAIL first_subkey: valid=%b idx=%0d subkey=%h expected 1 0 03020100",
                     subkey_valid, round_idx, subkey);
        else pass_count++;
        subkey_ack = 1'b1;
        @(negedge clk);
        subkey_ack = 1'b0;
        check_count++;
        if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd1, 32'h131d0309})
            $display("FAIL second_subkey: valid=%b idx=%0d subkey=%h expected 1 1 131d0309",
                     subkey_valid, round_idx, subkey);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd1, 32'h131d0309})
            $display("FAIL hold_without_ack: valid=%b idx=%0d subkey=%h expected 1 1 131d0309",
                     subkey_valid, round_idx, subkey);
        else pass_count++;
    endtask

    task automatic test_full_run();
        int bad;
        do_reset();
        pulse_load(KEY_A);
        @(negedge clk);
        subkey_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < R; i++) begin
            check_count++;
            if ({subkey_valid, busy, round_idx, subkey} !== {1'b1, 1'b1, IW'(i), exp_keys[i]}) begin
                $display("FAIL full_run_round: idx=%0d subkey=%h valid=%b busy=%b expected idx=%0d subkey=%h",
                         round_idx, subkey, subkey_valid, busy, i, exp_keys[i]);
                bad++;
            end else pass_count++;
            @(negedge clk);
        end
        subkey_ack = 1'b0;
        check_count++;
        if ({done, subkey_valid, busy, state_response, subkey} !== {1'b1, 1'b0, 1'b0, 3'd3, exp_keys[R-1]})
            $display("FAIL full_run_done: done=%b valid=%b busy=%b state=%0d subkey=%h expected 1 0 0 3 %h",
                     done, subkey_valid, busy, state_response, subkey, exp_keys[R-1]);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if ({done, busy, state_response} !== {1'b0, 1'b0, 3'd0})
            $display("FAIL full_run_return_idle: done=%b busy=%b state=%0d expected 0 0 0",
                     done, busy, state_response);
        else pass_count++;
    endtask

    task automatic test_backpressure();
        do_reset();
        pulse_load(KEY_A);
        @(negedge clk);
        subkey_ack = 1'b1;
        for (int i = 0; i < R; i++) begin
            if (i == 4) begin
                subkey_ack = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check_count++;
                    if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd4, exp_keys[4]})
                        $display("FAIL backpressure_hold: cycle=%0d idx=%0d subkey=%h expected 4 %h",
                                 s, round_idx, subkey, exp_keys[4]);
                    else pass_count++;
                    @(negedge clk);
                end
                subkey_ack = 1'b1;
            end
            check_count++;
            if ({subkey_valid, round_idx, subkey} !== {1'b1, IW'(i), exp_keys[i]})
                $display("FAIL backpressure_round: idx=%0d subkey=%h expected idx=%0d subkey=%h",
                         round_idx, subkey, i, exp_keys[i]);
            else pass_count++;
            @(negedge clk);
        end
        subkey_ack = 1'b0;
        check_count++;
        if ({done, state_response} !== {1'b1, 3'd3})
            $display("FAIL backpressure_done: done=%b state=%0d expected 1 3", done, state_response);
        else pass_count++;
    endtask

    task automatic test_abort();
        do_reset();
        pulse_load(KEY_A);
        @(negedge clk);
        subkey_ack = 1'b1;
        repeat (10) @(negedge clk);
        check_count++;
        if ({round_idx, subkey} !== {5'd10, exp_keys[10]})
            $display("FAIL abort_reach_round10: idx=%0d subkey=%h expected 10 %h",
                     round_idx, subkey, exp_keys[10]);
        else pass_count++;
        rst = 1'b1;
        subkey_ack = 1'b0;
        #1;
        check_count++;
        if ({subkey, subkey_valid, round_idx, busy, done, state_response} !== '0)
            $display("FAIL abort_outputs: subkey=%h valid=%b idx=%0d busy=%b state=%0d expected all zero",
                     subkey, subkey_valid, round_idx, busy, state_response);
        else pass_count++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_count++;
        if ({subkey_valid, busy, state_response} !== {1'b0, 1'b0, 3'd0})
            $display("FAIL abort_stays_idle: valid=%b busy=%b state=%0d expected 0 0 0",
                     subkey_valid, busy, state_response);
        else pass_count++;
        pulse_load(KEY_A);
        @(negedge clk);
        check_count++;
        if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd0, 32'h03020100})
            $display("FAIL abort_reload: valid=%b idx=%0d subkey=%h expected 1 0 03020100",
                     subkey_valid, round_idx, subkey);
        else pass_count++;
    endtask

    task automatic test_load_ignored_while_busy();
        do_reset();
        subkey_ack = 1'b0;
        @(negedge clk);
        key = KEY_A;
        key_load = 1'b1;
        @(negedge clk);
        // In LOAD now: a second load with a different key must be ignored.
        key = KEY_B;
        @(negedge clk);
        subkey_ack = 1'b1;
        for (int i = 0; i < R; i++) begin
            check_count++;
            if ({subkey_valid, round_idx, subkey} !== {1'b1, IW'(i), exp_keys[i]})
                $display("FAIL busy_load_ignored: idx=%0d subkey=%h expected idx=%0d subkey=%h",
                         round_idx, subkey, i, exp_keys[i]);
            else pass_count++;
            if (i == R - 1) key_load = 1'b0;
            @(negedge clk);
        end
        subkey_ack = 1'b0;
        check_count++;
        if ({done, state_response} !== {1'b1, 3'd3})
            $display("FAIL busy_load_done: done=%b state=%0d expected 1 3", done, state_response);
        else pass_count++;
    endtask

    task automatic test_restart_in_done();
        do_reset();
        pulse_load(KEY_A);
        @(negedge clk);
        subkey_ack = 1'b1;
        repeat (R - 1) @(negedge clk);
        check_count++;
        if ({round_idx, subkey} !== {5'd26, exp_keys[R-1]})
            $display("FAIL restart_last_round: idx=%0d subkey=%h expected 26 %h",
                     round_idx, subkey, exp_keys[R-1]);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if ({done, state_response} !== {1'b1, 3'd3})
            $display("FAIL restart_in_done: done=%b state=%0d expected 1 3", done, state_response);
        else pass_count++;
        key = KEY_A;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        subkey_ack = 1'b0;
        check_count++;
        if ({state_response, busy, subkey_valid, done} !== {3'd1, 1'b1, 1'b0, 1'b0})
            $display("FAIL restart_load_state: state=%0d busy=%b valid=%b done=%b expected 1 1 0 0",
                     state_response, busy, subkey_valid, done);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if ({subkey_valid, round_idx, subkey} !== {1'b1, 5'd0, 32'h03020100})
            $display("FAIL restart_first_subkey: valid=%b idx=%0d subkey=%h expected 1 0 03020100",
                     subkey_valid, round_idx, subkey);
        else pass_count++;
    endtask

    initial begin
        build_model(KEY_A);
        test_reset();
        test_vector_load();
        test_full_run();
        test_backpressure();
        test_abort();
        test_load_ignored_while_busy();
        test_restart_in_done();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/speck_key_schedule.md
Name: speck_key_schedule

Overview:
- Upstream neighbour of the SPECK round-encrypt stage: expands the master key into the per-round subkeys, one word per round.
- Presents each subkey on a valid/ack handshake, so the round stage's subkey input is fed round by round.
- Subkeys follow the SPECK key expansion: modular add, rotate, XOR with the round index.
- Defaults match SPECK64/128: 32-bit words, 4 key words, 27 rounds.

Parameters:
- WORD_SIZE, 32, width of one key/subkey word. Equals the round stage's BLOCK_SIZE.
- KEY_WORDS, 4, number m of master-key words (2..4).
- ROUNDS, 27, number of subkeys produced.
- ALPHA, 8, right-rotate amount applied to the l word.
- BETA, 3, left-rotate amount applied to the k word.
- IDX_W, 5, round index width; must satisfy 2^IDX_W >= ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key  in  KEY_WORDS*WORD_SIZE  master key {l[m-2],...,l[0],k[0]}; k[0] occupies the least-significant word.
- key_load  in  1  start expansion; sampled only in IDLE or DONE.
- subkey  out  WORD_SIZE  current round key k[i].
- subkey_valid  out  1  subkey/round_idx valid.
- subkey_ack  in  1  consumer has taken the current subkey.
- round_idx  out  IDX_W  index i of the presented subkey.
- busy  out  1  high in LOAD and EMIT.
- done  out  1  one-cycle pulse after the last subkey is acked.
- state_response  out  3  debug copy of the state encoding.

Behaviour:
- Reset: asynchronous, active-high; all state and outputs are reset. State goes to IDLE. subkey, round_idx and k/l registers go to 0. subkey_valid, busy and done go to 0.
- Reset mid-operation: expansion is abandoned; a new key_load is required afterwards.
- IDLE: on key_load=1, latch k<=key[W-1:0] and l[j]<=key word j+1, then go to LOAD.
- LOAD: one cycle, busy=1, then go to EMIT with round_idx=0.
  - Latency: subkey_valid rises 2 cycles after the key_load edge.
- EMIT: subkey_valid=1, subkey=k, round_idx=i.
  - ack low: all outputs hold stable.
  - ack high and i<ROUNDS-1: at that edge, apply the step below and set i<=i+1. Stay in EMIT with no bubble, so one subkey is produced per acked cycle.
  - ack high and i=ROUNDS-1: go to DONE, drop subkey_valid, pulse done for exactly one cycle.
  - subkey_ack while subkey_valid=0: ignored.
- Step, combinational, all arithmetic mod 2^WORD_SIZE:
  - nl = (k + ROR(l[0],ALPHA)) ^ zero-extended i.
  - nk = ROL(k,BETA) ^ nl.
  - Shift the l buffer down: l[j]<=l[j+1], l[m-2]<=nl. Then k<=nk.
  - Rotates are true rotates (no bit lost) for any amount < WORD_SIZE.
- DONE: subkey holds the last key, done=0 after its first cycle.
  - key_load restarts exactly as from IDLE.
  - Without key_load, returns to IDLE one cycle later.
- key_load in LOAD/EMIT: ignored; the current expansion is unaffected.
- key_load and subkey_ack in the same cycle in DONE: key_load wins.
- KEY_WORDS=2: the l buffer has a single word; the shift degenerates to l[0]<=nl.
- States: IDLE=0, LOAD=1, EMIT=2, DONE=3; other encodings return to IDLE.

Decomposition:
- cipher_settings.vh gains SPECK_ALPHA, SPECK_BETA and SPECK_ROUNDS defaults.
- key_schedule_defines.vh holds the state encodings and MAX_STATE.
- Sub-module speck_key_step: purely combinational (k, l0, i) -> (nk, nl). It is parameterised on WORD_SIZE, ALPHA and BETA, and reused by a later decrypt-side schedule.

Test Plan:
- Reset: assert rst mid-clock with no clk edge -> all outputs 0 immediately; state_response=0.
- Vector load: key=0x1b1a1918_13121110_0b0a0908_03020100, pulse key_load.
  - 2 cycles later: subkey_valid=1, round_idx=0, subkey=0x03020100.
  - Ack once -> subkey=0x131d0309, round_idx=1.
- Full run: ack held high -> 27 consecutive subkeys match the software SPECK64/128 model; done pulses once after round_idx=26; busy falls.
- Backpressure: hold ack low for 5 cycles at round 4 -> subkey/round_idx stable; after release, the sequence is identical to the full run.
- Abort: at round 10, pulse rst -> outputs 0, state IDLE. Then key_load gives round_idx=0 and subkey=0x03020100 again.
- Load rules:
  - key_load=1 while busy with a different key -> ignored, current sequence unchanged.
  - key_load with subkey_ack in DONE -> restart, first subkey again 0x03020100.
